// File: rtl/sequential_detector_pkg.sv
// Shared types, default pattern and the KMP-style next-state function
// for the serial pattern detector.
package seq_det_pkg;

    localparam int         MAX_PAT_LEN = 16;
    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         STATE_W     = $clog2(DEF_PAT_LEN + 1);

    // Names for the default 4-bit pattern; the encoding is the match length k.
    typedef enum logic [STATE_W-1:0] {
        IDLE     = STATE_W'(0),
        S0       = STATE_W'(1),
        S1       = STATE_W'(2),
        S2       = STATE_W'(3),
        DETECTED = STATE_W'(4)
    } state_e;

    // Next match length from match length k after seeing bit b.
    // Pattern bit i (i=0 is the first bit received) lives at pattern[len-1-i].
    // A full match without overlap restarts exactly like IDLE.
    function automatic int next_state(input int k, input logic b,
                                      input logic [MAX_PAT_LEN-1:0] pattern,
                                      input int len, input bit overlap);
        int                   ke;
        int                   res;
        bit                   ok;
        logic [MAX_PAT_LEN:0] s;
        res = 0;
        s   = '0;
        if (k <= len) begin
            ke = (k == len && !overlap) ? 0 : k;
            if (ke < len && b == pattern[len-1-ke]) begin
                res = ke + 1;
            end else begin
                // s = matched prefix followed by b; keep the longest proper
                // suffix of s that is also a prefix of the pattern.
                for (int i = 0; i < ke; i++) s[i] = pattern[len-1-i];
                s[ke] = b;
                for (int l = 1; l <= ke && l <= len; l++) begin
                    ok = 1'b1;
                    for (int j = 0; j < l; j++)
                        if (s[ke+1-l+j] != pattern[len-1-j]) ok = 1'b0;
                    if (ok) res = l;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sequential_detector_if.sv
// Serial data in / detection flag out between source and detector.
interface sequential_detector_if;
    logic data_in;
    logic detection_out;

    modport master (output data_in, input  detection_out);
    modport slave  (input  data_in, output detection_out);
endinterface

// File: rtl/sequential_detector_next_table.sv
// Elaborated next-state lookup: every (state, bit) entry is a constant
// produced by next_state(), so the hardware is a small mux of constants.
module seq_det_next_table
    import seq_det_pkg::*;
#(
    parameter int               PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit               OVERLAP = 1'b1,
    parameter int               SW      = $clog2(PAT_LEN + 1)
) (
    input  logic [SW-1:0] state_i,
    input  logic          b_i,
    output logic [SW-1:0] next_o
);

    logic [PAT_LEN:0][1:0][SW-1:0] tbl;

    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_k
        for (genvar bb = 0; bb < 2; bb++) begin : g_b
            localparam int N = next_state(k, 1'(bb), MAX_PAT_LEN'(PATTERN),
                                          PAT_LEN, OVERLAP);
            assign tbl[k][bb] = SW'(N);
        end
    end

    // Encodings above PAT_LEN are unreachable; send them back to IDLE.
    always_comb begin
        next_o = '0;
        if (state_i <= SW'(PAT_LEN)) next_o = tbl[state_i][b_i];
    end

endmodule

// File: rtl/sequential_detector.sv
// Moore serial pattern detector: match-length state register plus a
// registered DETECTED flag.
module sequential_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    sequential_detector_if.slave  bus
);

    localparam int SW = $clog2(PAT_LEN + 1);

    logic [SW-1:0] state_q, state_d;
    logic          det_q, det_d;

    seq_det_next_table #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_tbl (
        .state_i (state_q),
        .b_i     (bus.data_in),
        .next_o  (state_d)
    );

    // Flag follows the next state so the output is a flop, not decode logic.
    always_comb begin
        det_d = (state_d == SW'(PAT_LEN));
    end

    // State and output registers; reset drops any partial match at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
        end
    end

    assign bus.detection_out = det_q;

endmodule

// File: tb/tb_sequential_detector.sv
// Directed bench: five detector configurations share one serial stream.
module tb_sequential_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sequential_detector_if ifa ();  // 1011 overlap
    sequential_detector_if ifb ();  // 1011 no overlap
    sequential_detector_if ifc ();  // 111 overlap
    sequential_detector_if ifd ();  // 111 no overlap
    sequential_detector_if ife ();  // single bit 0

    assign ifa.data_in = d;
    assign ifb.data_in = d;
    assign ifc.data_in = d;
    assign ifd.data_in = d;
    assign ife.data_in = d;

    sequential_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1))
        u_a (.clk(clk), .reset(reset), .bus(ifa));
    sequential_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0))
        u_b (.clk(clk), .reset(reset), .bus(ifb));
    sequential_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1))
        u_c (.clk(clk), .reset(reset), .bus(ifc));
    sequential_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0))
        u_d (.clk(clk), .reset(reset), .bus(ifd));
    sequential_detector #(.PAT_LEN(1), .PATTERN(1'b0), .OVERLAP(1'b1))
        u_e (.clk(clk), .reset(reset), .bus(ife));

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive b between edges, sample 1 time unit after the rising edge.
    task automatic step(input logic b);
        @(negedge clk);
        d = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        d     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [10:0] near;
    logic [10:0] near_exp;
    logic [6:0]  ovl;
    logic [6:0]  ovl_a;
    logic [6:0]  ovl_b;
    logic [5:0]  c_exp;
    logic [5:0]  d_exp;

    initial begin
        // Reset held with toggling data: nothing may detect.
        for (int i = 0; i < 2; i++) begin
            step(1'(i));
            chk("rst_hold_a", ifa.detection_out, 1'b0);
            chk("rst_hold_e", ife.detection_out, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Basic match 1,0,1,1,0 -> high only after the 4th edge.
        step(1'b1); chk("basic1", ifa.detection_out, 1'b0);
        step(1'b0); chk("basic2", ifa.detection_out, 1'b0);
        step(1'b1); chk("basic3", ifa.detection_out, 1'b0);
        step(1'b1); chk("basic4", ifa.detection_out, 1'b1);
        chk("basic4_noovl", ifb.detection_out, 1'b1);
        step(1'b0); chk("basic5", ifa.detection_out, 1'b0);

        // Asynchronous reset while the flag is high clears it before any edge.
        do_reset();
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        chk("pre_async", ifa.detection_out, 1'b1);
        #2 reset = 1'b0;
        #1 chk("async_clear", ifa.detection_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-match after "101": a following "1" must not detect.
        step(1'b1); step(1'b0); step(1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midmatch_rst", ifa.detection_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1); chk("midmatch_after", ifa.detection_out, 1'b0);

        // Overlap vs non-overlap on 1,0,1,1,0,1,1 (MSB first).
        do_reset();
        ovl   = 7'b1011011;
        ovl_a = 7'b0001001;
        ovl_b = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            step(ovl[i]);
            chk("ovl_a", ifa.detection_out, ovl_a[i]);
            chk("ovl_b", ifb.detection_out, ovl_b[i]);
        end
        // Non-overlap instance finds a fresh 1011 afterwards.
        step(1'b1); chk("noovl_r1", ifb.detection_out, 1'b0);
        step(1'b0); chk("noovl_r2", ifb.detection_out, 1'b0);
        step(1'b1); chk("noovl_r3", ifb.detection_out, 1'b0);
        step(1'b1); chk("noovl_r4", ifb.detection_out, 1'b1);

        // Near misses: only the final edge completes 1011; single-bit
        // instance detects on every 0.
        do_reset();
        near     = 11'b10011101011;
        near_exp = 11'b00000000001;
        for (int i = 10; i >= 0; i--) begin
            step(near[i]);
            chk("near_a", ifa.detection_out, near_exp[i]);
            chk("len1_e", ife.detection_out, ~near[i]);
        end

        // Pattern 111, data held at 1 for six edges.
        do_reset();
        c_exp = 6'b001111;
        d_exp = 6'b001001;
        for (int i = 5; i >= 0; i--) begin
            step(1'b1);
            chk("ones_ovl", ifc.detection_out, c_exp[i]);
            chk("ones_noovl", ifd.detection_out, d_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sequential_detector.md
Name: sequential_detector

Overview:
- Serial bit-pattern detector, implemented as a Moore FSM.
- Samples one bit of `data_in` per rising clock edge.
- Asserts `detection_out` for one cycle when the last PAT_LEN sampled bits equal PATTERN.
- Sits on a serial data path as a framing/sync-word detector; output is registered and glitch-free.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 1..16.
- PATTERN, 4'b1011, target sequence, PAT_LEN bits wide; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = search restarts from IDLE after each match.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- data_in  input  1  serial data bit, sampled on each rising clk edge.
- detection_out  output  1  high for the cycle in which the FSM is in the DETECTED state.

Behaviour:
- State encodes match length k = 0..PAT_LEN (number of pattern prefix bits currently matched).
- Default state names:
  - IDLE (k=0)
  - S0 (k=1, "1")
  - S1 (k=2, "10")
  - S2 (k=3, "101")
  - DETECTED (k=PAT_LEN)
- Reset (reset low, asynchronous): state = IDLE, detection_out = 0 immediately, independent of clk. Deassertion takes effect at the next rising edge.
- Each rising edge with reset high, state k, input b:
  - If k<PAT_LEN and b equals pattern bit k (counting from the first bit), next = k+1.
  - Otherwise next = length of the longest proper suffix of (matched prefix, then b) that is also a prefix of PATTERN. This is the KMP failure rule.
  - From DETECTED: with OVERLAP=1 apply the same suffix rule. With OVERLAP=0 behave exactly as IDLE.
- The transition table is computed at elaboration by a constant function from PATTERN/PAT_LEN. There is no runtime pattern programming.
- Default transitions (1011):
  - IDLE: 1→S0, 0→IDLE
  - S0: 0→S1, 1→S0
  - S1: 1→S2, 0→IDLE
  - S2: 1→DETECTED, 0→S1
  - DETECTED (OVERLAP=1): 0→S1, 1→S0
  - DETECTED (OVERLAP=0): 1→S0, 0→IDLE
- detection_out is a Moore output: 1 iff state==DETECTED.
  - Latency: goes high right after the rising edge that samples the final pattern bit.
  - Stays high exactly one clock, unless a back-to-back match is possible (e.g. PATTERN all ones with OVERLAP=1, where it stays high continuously).
- Illegal or unreachable state encodings recover to IDLE on the next edge; detection_out = 0 in them.
- Reset asserted mid-match discards progress; the next match needs a full PAT_LEN bits after reset release.
- PAT_LEN=1: DETECTED whenever the sampled bit equals PATTERN[0].

Decomposition:
- Shared package seq_det_pkg holds:
  - the state typedef (enum for the default names, plus a width constant $clog2(PAT_LEN+1));
  - the default PATTERN/PAT_LEN constants;
  - the constant function next_state(k, b, pattern, len, overlap).
- One sub-module is natural: seq_det_next_table. It is purely combinational/elaborated, turns the parameters into the next-state lookup, and is instantiated by sequential_detector, which holds the state register and output decode.

Test Plan:
- Reset: hold reset low 2 cycles with data_in toggling → detection_out=0, state IDLE throughout; assert reset low mid-match (after "101") → output stays 0 and "1" after release does not detect.
- Basic match: after reset high, feed 1,0,1,1,0 on successive edges → detection_out=0,0,0,1,0 in the cycles after each edge (high only after the 4th edge).
- Overlap (OVERLAP=1): feed 1,0,1,1,0,1,1 → detection_out high after edges 4 and 7 only.
- Non-overlap (OVERLAP=0): same stream 1,0,1,1,0,1,1 → high after edge 4 only; then 1,0,1,1 → high again after its 4th bit.
- Near misses: feed 1,0,0,1,1,1,0,1,0,1,1 → single detection after the final edge (tests the S1→IDLE, S0→S0 and S2→S1 fallbacks).
- Parameter sweep: PATTERN=3'b111, PAT_LEN=3, OVERLAP=1, data_in held at 1 for 6 edges → detection_out high from edge 3 onward continuously; with OVERLAP=0 → high after edges 3 and 6 only.
